// File: rtl/lcv_alu_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : lcv_alu_sched_if
// Brief    : Requester / shared-ALU / response bundle for lcv_alu_sched.
// Revision : 1.0 - initial release
// ============================================================================
interface lcv_alu_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ*3-1:0]     req_op;
    logic [WIDTH-1:0]         alu_a;
    logic [WIDTH-1:0]         alu_b;
    logic [2:0]               alu_op;
    logic [WIDTH-1:0]         alu_result;
    logic [NUM_REQ-1:0]       rsp_valid;
    logic [NUM_REQ-1:0]       rsp_ready;
    logic [NUM_REQ*WIDTH-1:0] rsp_data;
    logic                     busy;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready, alu_result,
        input  req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_data, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready, alu_result,
        output req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_data, busy
    );
endinterface
`default_nettype wire

// File: rtl/lcv_alu_sched.sv
`default_nettype none
// ============================================================================
// Module   : lcv_alu_sched
// Brief    : Round-robin issue of NUM_REQ requesters onto one pipelined ALU,
//            with tag tracking and per-requester response holding registers.
// Revision : 1.0 - initial release
// ============================================================================
module lcv_alu_sched #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int LATENCY = 1
) (
    input  wire logic      clk,
    input  wire logic      rst,
    lcv_alu_sched_if.slave io_bus
);
    localparam int         c_PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [2:0] c_OP_ZERO = 3'd7;

    logic [NUM_REQ-1:0] r_pending;
    logic [NUM_REQ-1:0] r_rsp_valid;
    logic [WIDTH-1:0]   r_rsp_data [NUM_REQ];
    logic [c_PTR_W-1:0] r_rr_ptr;
    logic [LATENCY-1:0] r_tag_vld;
    logic [c_PTR_W-1:0] r_tag_idx [LATENCY];
    logic               r_busy;

    logic [NUM_REQ-1:0] w_elig;
    logic [NUM_REQ-1:0] w_gnt_oh;
    logic [NUM_REQ-1:0] w_rsp_hs;
    logic [NUM_REQ-1:0] w_pending_nxt;
    logic               w_gnt_vld;
    logic [c_PTR_W-1:0] w_gnt_idx;
    logic [c_PTR_W-1:0] w_ptr_nxt;

    // Grants are suppressed while reset is held so the ALU sees only ZERO.
    assign w_elig = io_bus.req_valid & ~r_pending & {NUM_REQ{~rst}};

    always_comb begin
        int v_idx;
        v_idx     = 0;
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            v_idx = (int'(r_rr_ptr) + k) % NUM_REQ;
            if (!w_gnt_vld && w_elig[c_PTR_W'(v_idx)]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = c_PTR_W'(v_idx);
            end
        end
    end

    assign w_ptr_nxt     = (w_gnt_idx == c_PTR_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
    assign w_gnt_oh      = w_gnt_vld ? (NUM_REQ'(1) << w_gnt_idx) : '0;
    assign w_rsp_hs      = r_rsp_valid & io_bus.rsp_ready;
    assign w_pending_nxt = (r_pending | w_gnt_oh) & ~w_rsp_hs;

    assign io_bus.req_ready = w_gnt_oh;
    assign io_bus.alu_a     = w_gnt_vld ? io_bus.req_a[int'(w_gnt_idx)*WIDTH +: WIDTH] : '0;
    assign io_bus.alu_b     = w_gnt_vld ? io_bus.req_b[int'(w_gnt_idx)*WIDTH +: WIDTH] : '0;
    assign io_bus.alu_op    = w_gnt_vld ? io_bus.req_op[int'(w_gnt_idx)*3 +: 3] : c_OP_ZERO;
    assign io_bus.rsp_valid = r_rsp_valid;
    assign io_bus.busy      = r_busy;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rsp_pack
            assign io_bus.rsp_data[gi*WIDTH +: WIDTH] = r_rsp_data[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending   <= '0;
            r_rsp_valid <= '0;
            r_rr_ptr    <= '0;
            r_tag_vld   <= '0;
            r_busy      <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                r_rsp_data[i] <= '0;
            end
            for (int s = 0; s < LATENCY; s++) begin
                r_tag_idx[s] <= '0;
            end
        end else begin
            r_pending <= w_pending_nxt;
            r_busy    <= |w_pending_nxt;
            if (w_gnt_vld) begin
                r_rr_ptr <= w_ptr_nxt;
            end
            r_tag_vld[0] <= w_gnt_vld;
            r_tag_idx[0] <= w_gnt_idx;
            for (int s = 1; s < LATENCY; s++) begin
                r_tag_vld[s] <= r_tag_vld[s-1];
                r_tag_idx[s] <= r_tag_idx[s-1];
            end
            // A write and a handshake never target the same index in one cycle.
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_rsp_hs[i]) begin
                    r_rsp_valid[i] <= 1'b0;
                end
                if (r_tag_vld[LATENCY-1] && (r_tag_idx[LATENCY-1] == c_PTR_W'(i))) begin
                    r_rsp_valid[i] <= 1'b1;
                    r_rsp_data[i]  <= io_bus.alu_result;
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_lcv_alu_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcv_alu_sched
// Brief    : Randomized scoreboard bench for lcv_alu_sched with a behavioural
//            pipelined ALU and reference arbitration model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcv_alu_sched;
    localparam int NR  = 4;
    localparam int W   = 32;
    localparam int LAT = 3;

    typedef struct {
        logic [W-1:0] d;
        int           t;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lcv_alu_sched_if #(.NUM_REQ(NR), .WIDTH(W)) bus ();

    lcv_alu_sched #(.NUM_REQ(NR), .WIDTH(W), .LATENCY(LAT)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] alu_ref(logic [W-1:0] a, logic [W-1:0] b, logic [2:0] op);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return W'(a < b);
            3'd3:    return W'($signed(a) < $signed(b));
            3'd4:    return a & b;
            3'd5:    return a | b;
            3'd6:    return a ^ b;
            default: return '0;
        endcase
    endfunction

    // Behavioural shared ALU: result appears LAT cycles after the issue cycle.
    logic [W-1:0] apipe [LAT];
    always @(posedge clk) begin
        apipe[0] <= alu_ref(bus.alu_a, bus.alu_b, bus.alu_op);
        for (int s = 1; s < LAT; s++) apipe[s] <= apipe[s-1];
    end
    assign bus.alu_result = apipe[LAT-1];

    logic [NR-1:0] have;
    logic [W-1:0]  oa [NR];
    logic [W-1:0]  ob [NR];
    logic [2:0]    oo [NR];
    logic [NR-1:0] mpend;
    logic [NR-1:0] seen;
    logic [NR-1:0] rdy_mask;
    bit            rnd_rdy;
    int            mptr;
    exp_t          sb [NR][$];
    int            n_chk  = 0;
    int            n_pass = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 4))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return 32'h1;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic set_op(int i, logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b);
        oo[i] = op; oa[i] = a; ob[i] = b; have[i] = 1'b1;
    endtask

    task automatic new_op(int i);
        set_op(i, 3'($urandom_range(0, 7)), pick(), pick());
    endtask

    task automatic apply();
        for (int i = 0; i < NR; i++) begin
            bus.req_valid[i]         = have[i];
            bus.req_a[i*W +: W]      = oa[i];
            bus.req_b[i*W +: W]      = ob[i];
            bus.req_op[i*3 +: 3]     = oo[i];
        end
        bus.rsp_ready = rnd_rdy ? NR'($urandom) : rdy_mask;
    endtask

    // One cycle of stimulus plus the reference arbitration decision.
    task automatic step();
        int            g;
        logic [NR-1:0] eg;
        exp_t          e;
        @(negedge clk);
        apply();
        #1;
        chk("busy", bus.busy, |mpend);
        g = -1;
        for (int k = 0; k < NR; k++) begin
            int idx;
            idx = (mptr + k) % NR;
            if (g < 0 && have[idx] && !mpend[idx]) g = idx;
        end
        eg = '0;
        if (g >= 0) eg[g] = 1'b1;
        chk("req_ready", bus.req_ready, eg);
        if (g >= 0) begin
            chk("alu_a", bus.alu_a, oa[g]);
            chk("alu_b", bus.alu_b, ob[g]);
            chk("alu_op", bus.alu_op, oo[g]);
            e.d = alu_ref(oa[g], ob[g], oo[g]);
            e.t = cyc;
            sb[g].push_back(e);
            mpend[g] = 1'b1;
            mptr     = (g + 1) % NR;
            have[g]  = 1'b0;
        end else begin
            chk("idle_op", bus.alu_op, 3'd7);
            chk("idle_a", bus.alu_a, 0);
            chk("idle_b", bus.alu_b, 0);
        end
    endtask

    task automatic do_reset(int ncyc);
        @(negedge clk);
        rst = 1'b1;
        apply();
        #1;
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_alu_op", bus.alu_op, 3'd7);
        chk("rst_alu_a", bus.alu_a, 0);
        mpend = '0;
        seen  = '0;
        mptr  = 0;
        for (int i = 0; i < NR; i++) sb[i].delete();
        repeat (ncyc) @(negedge clk);
        bus.req_valid = '0;
        rst = 1'b0;
    endtask

    task automatic drain();
        int outstanding;
        rnd_rdy  = 1'b0;
        rdy_mask = '1;
        outstanding = 1;
        for (int n = 0; n < 60 && outstanding != 0; n++) begin
            step();
            outstanding = int'(have != '0);
            for (int i = 0; i < NR; i++) outstanding += sb[i].size();
        end
        chk("drain_outstanding", outstanding, 0);
    endtask

    // Response monitor: compares held data every cycle, retires on handshake.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                for (int i = 0; i < NR; i++) begin
                    if (bus.rsp_valid[i]) begin
                        if (sb[i].size() == 0) begin
                            chk("rsp_unexpected", {63'd0, bus.rsp_valid[i]}, 0);
                        end else begin
                            if (!seen[i]) begin
                                chk("rsp_latency", cyc, sb[i][0].t + LAT + 1);
                                seen[i] = 1'b1;
                            end
                            chk("rsp_data", bus.rsp_data[i*W +: W], sb[i][0].d);
                            if (bus.rsp_ready[i]) begin
                                void'(sb[i].pop_front());
                                seen[i]  = 1'b0;
                                mpend[i] = 1'b0;
                            end
                        end
                    end else if (sb[i].size() != 0) begin
                        chk("rsp_timely", {63'd0, (cyc <= sb[i][0].t + LAT + 1)}, 1);
                    end
                end
            end
        end
    end

    initial begin
        have     = '0;
        mpend    = '0;
        seen     = '0;
        mptr     = 0;
        rnd_rdy  = 1'b0;
        rdy_mask = '1;
        for (int i = 0; i < NR; i++) begin
            oa[i] = '0; ob[i] = '0; oo[i] = 3'd7;
        end
        apply();
        do_reset(2);

        repeat (4) step();

        set_op(0, 3'd0, 32'd5, 32'd7);
        repeat (8) step();

        for (int i = 0; i < NR; i++) new_op(i);
        repeat (20) begin
            for (int i = 0; i < NR; i++) if (!have[i]) new_op(i);
            step();
        end
        drain();

        for (int i = 0; i < NR; i++) new_op(i);
        set_op(2, 3'd1, 32'd3, 32'd5);
        rdy_mask = 4'b1011;
        repeat (12) begin
            for (int i = 0; i < NR; i++) if (!have[i]) new_op(i);
            step();
        end
        drain();

        set_op(1, 3'd3, 32'hFFFF_FFFF, 32'd1);
        set_op(3, 3'd2, 32'hFFFF_FFFF, 32'd1);
        repeat (8) step();
        drain();

        set_op(0, 3'd0, 32'h1234_5678, 32'h1111_1111);
        step();
        set_op(1, 3'd6, 32'hA5A5_A5A5, 32'hFFFF_0000);
        do_reset(2);
        repeat (6) step();
        drain();

        rnd_rdy = 1'b1;
        repeat (1500) begin
            for (int i = 0; i < NR; i++) if (!have[i] && $urandom_range(0, 1) == 1) new_op(i);
            step();
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
